ifid_fetch_stage: RTL

Instruction-fetch stage and IF/ID pipeline register of the MIPS core: generates the instruction-memory address each cycle, captures the returned instruction into IF/ID, and applies the pipeline-control decisions from downstream. It consumes the load-use hazard detector's `load_use_en` (stall), the EX-stage branch/jump redirect (flush) and an external halt. It feeds `ifid_rs`/`ifid_rt` back to the hazard detector and drives `idex_bubble` to the ID/EX register. Instruction memory is synchronous: the address presented at edge N returns data during cycle N+1.

---
 rtl/ifid_pkg.sv | 30 +++
 rtl/ifid_perf_cnt.sv | 36 +++
 rtl/ifid_fetch_stage.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ifid_pkg.sv
// Shared definitions for the instruction-fetch stage and IF/ID register:
// fetch FSM encodings, PC increment, default NOP word and the MIPS rs/rt
// field positions that the hazard detector also relies on.
package ifid_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } ifid_state_e;

  localparam logic [31:0] PC_INC   = 32'd4;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  // Extract the rs source-register field of a MIPS instruction.
  function automatic logic [4:0] instr_rs(input logic [31:0] instr);
    return instr[RS_MSB:RS_LSB];
  endfunction

  // Extract the rt source/target-register field of a MIPS instruction.
  function automatic logic [4:0] instr_rt(input logic [31:0] instr);
    return instr[RT_MSB:RT_LSB];
  endfunction

endpackage

// File: rtl/ifid_perf_cnt.sv
// Saturating event counter used for the fetch-stage performance counters.
// Counts one per cycle with inc high and sticks at all-ones.
module ifid_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: increment on event unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ifid_fetch_stage.sv
// MIPS instruction-fetch stage with the IF/ID pipeline register.
// Generates the instruction-memory address, captures the returned word and
// applies stall (load-use), flush (EX redirect) and halt control.
// Optional feature macro: IFID_PERF_CNT_EN enables the stall/flush counters;
// when undefined both counter ports are tied to zero.
module ifid_fetch_stage
  import ifid_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_WORD,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use_en,
  input  logic             redirect_en,
  input  logic [31:0]      redirect_pc,
  input  logic             halt_req,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      ifid_instr,
  output logic [31:0]      ifid_pc4,
  output logic             ifid_valid,
  output logic [4:0]       ifid_rs,
  output logic [4:0]       ifid_rt,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  ifid_state_e state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic        stall;
  logic        freeze;
  logic [31:0] fetch_pc_inc;

  // Pipeline control decode and the instruction-memory address mux.
  // A redirect always overrides a stall because the branch is older.
  always_comb begin
    stall        = load_use_en & ifid_valid_q & (state_q == ST_RUN) & ~redirect_en;
    freeze       = stall | (state_q == ST_HALT) | (state_q == ST_BOOT);
    fetch_pc_inc = fetch_pc_q + PC_INC;
    idex_bubble  = stall | (state_q == ST_HALT) | redirect_en;
    if (rst) begin
      imem_addr = RESET_PC;
    end else if (redirect_en) begin
      imem_addr = redirect_pc;
    end else if (freeze) begin
      // Re-present the same address so the memory replays the held word.
      imem_addr = fetch_pc_q;
    end else begin
      imem_addr = fetch_pc_inc;
    end
    fetch_pc_d = imem_addr;
  end

  // IF/ID next-state: flush on redirect, hold on freeze, else capture.
  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    if (redirect_en) begin
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else if (freeze) begin
      ifid_instr_d = ifid_instr_q;
    end else begin
      ifid_instr_d = imem_rdata;
      ifid_pc4_d   = fetch_pc_inc;
      ifid_valid_d = fetch_valid_q;
    end
  end

  // Fetch FSM next-state: one BOOT cycle, then RUN/HALT under halt_req.
  always_comb begin
    state_d       = state_q;
    fetch_valid_d = fetch_valid_q;
    case (state_q)
      ST_BOOT: begin
        state_d       = ST_RUN;
        fetch_valid_d = 1'b1;
      end
      ST_RUN: begin
        if (halt_req && !redirect_en) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        if (!halt_req) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d       = ST_BOOT;
        fetch_valid_d = 1'b0;
      end
    endcase
  end

  // Fetch PC, FSM and IF/ID registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      fetch_pc_q    <= RESET_PC;
      fetch_valid_q <= 1'b0;
      ifid_instr_q  <= NOP_INSTR;
      ifid_pc4_q    <= 32'h0000_0000;
      ifid_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      fetch_valid_q <= fetch_valid_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_pc4_q    <= ifid_pc4_d;
      ifid_valid_q  <= ifid_valid_d;
    end
  end

  assign ifid_instr = ifid_instr_q;
  assign ifid_pc4   = ifid_pc4_q;
  assign ifid_valid = ifid_valid_q;
  assign ifid_rs    = instr_rs(ifid_instr_q);
  assign ifid_rt    = instr_rt(ifid_instr_q);

`ifdef IFID_PERF_CNT_EN
  ifid_perf_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall),
    .count (stall_cnt)
  );

  ifid_perf_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (redirect_en),
    .count (flush_cnt)
  );
`else
  assign stall_cnt = {CNT_W{1'b0}};
  assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule
